// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO write-side packer.
package fifo_pkg;

    localparam int unsigned MAX_LANES = 64;
    localparam int unsigned DEF_LANES = 4;

    // Lane-index width for a given lane count, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned lanes);
        return (lanes > 1) ? unsigned'($clog2(lanes)) : 1;
    endfunction

    localparam int unsigned DEF_IDX_W = idx_width(DEF_LANES);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    // Lowest set bit of mask at or above start, below lanes; returns lanes if none.
    function automatic int unsigned next_set_bit(input logic [MAX_LANES-1:0] mask,
                                                 input int unsigned         start,
                                                 input int unsigned         lanes);
        int unsigned res;
        res = lanes;
        for (int i = int'(MAX_LANES) - 1; i >= 0; i--) begin
            if (unsigned'(i) >= start && unsigned'(i) < lanes && mask[i]) begin
                res = unsigned'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fifo_write_packer_if.sv
// Input beat stream plus FIFO write port of the packer.
interface fifo_write_packer_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LANES      = 4
);
    logic                        s_valid;
    logic                        s_ready;
    logic [LANES*DATA_WIDTH-1:0] s_data;
    logic [LANES-1:0]            s_keep;
    logic                        s_last;
    logic                        wen;
    logic [DATA_WIDTH-1:0]       wdata;
    logic                        wfull;

    modport master (
        output s_valid, s_data, s_keep, s_last, wfull,
        input  s_ready, wen, wdata
    );

    modport slave (
        input  s_valid, s_data, s_keep, s_last, wfull,
        output s_ready, wen, wdata
    );
endinterface

// File: rtl/keep_lane_sel.sv
// Find-first-set over a keep mask at or above a start index.
module keep_lane_sel
    import fifo_pkg::*;
#(
    parameter  int unsigned LANES = 4,
    localparam int unsigned IDX_W = idx_width(LANES)
) (
    input  logic [LANES-1:0] mask,
    input  logic [IDX_W:0]   start,
    output logic [IDX_W-1:0] idx,
    output logic             none
);

    int unsigned pos;

    // Start may equal LANES, which always yields none.
    always_comb begin
        pos  = next_set_bit(MAX_LANES'(mask), 32'(start), LANES);
        idx  = IDX_W'(pos);
        none = (pos >= LANES);
    end

endmodule

// File: rtl/fifo_write_packer.sv
// Serialises kept byte lanes of wide beats into the FIFO write port.
module fifo_write_packer
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LANES      = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                 wclk,
    input  logic                 wrst_n,
    fifo_write_packer_if.slave   bus,
    output logic                 pkt_done,
    output logic [CNT_WIDTH-1:0] byte_count,
    output logic [CNT_WIDTH-1:0] pkt_count,
    output logic                 busy
);

    localparam int unsigned IDX_W  = idx_width(LANES);
    localparam int unsigned BEAT_W = LANES * DATA_WIDTH;

    localparam logic [0:0] S_IDLE = 1'(IDLE);
    localparam logic [0:0] S_SEND = 1'(SEND);

    logic [0:0]           state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [BEAT_W-1:0]    data_q, data_d;
    logic [LANES-1:0]     keep_q, keep_d;
    logic                 last_q, last_d;
    logic                 pkt_done_d;
    logic [CNT_WIDTH-1:0] byte_d, pkt_d;
    logic [1:0]           pkt_inc;

    logic [IDX_W-1:0]     load_idx, adv_idx;
    logic                 load_none, adv_none;
    logic [IDX_W:0]       adv_start;
    logic                 ready_c, write_ok, beat_take;

    // Lane selection for a newly loaded beat.
    keep_lane_sel #(.LANES(LANES)) u_load_sel (
        .mask  (bus.s_keep),
        .start ('0),
        .idx   (load_idx),
        .none  (load_none)
    );

    assign adv_start = {1'b0, idx_q} + (IDX_W+1)'(1);

    // Lane selection for the next kept lane above the current one.
    keep_lane_sel #(.LANES(LANES)) u_adv_sel (
        .mask  (keep_q),
        .start (adv_start),
        .idx   (adv_idx),
        .none  (adv_none)
    );

    // Ready when empty, or when the final lane leaves this cycle; low in reset.
    assign ready_c     = wrst_n && ((state_q == S_IDLE) || (adv_none && !bus.wfull));
    assign bus.s_ready = ready_c;
    assign bus.wen     = (state_q == S_SEND);
    assign busy        = (state_q == S_SEND);
    assign write_ok    = (state_q == S_SEND) && !bus.wfull;
    assign beat_take   = bus.s_valid && ready_c;

    // Write data mux over the held lanes.
    always_comb begin
        bus.wdata = data_q[DATA_WIDTH-1:0];
        for (int k = 0; k < int'(LANES); k++) begin
            if (idx_q == IDX_W'(k)) begin
                bus.wdata = data_q[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next state: lane advance, beat load and packet accounting.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;
        pkt_inc = 2'd0;
        byte_d  = byte_count + CNT_WIDTH'(write_ok);

        if (write_ok) begin
            if (!adv_none) begin
                idx_d = adv_idx;
            end else begin
                state_d = S_IDLE;
                if (last_q) begin
                    pkt_inc = pkt_inc + 2'd1;
                end
            end
        end

        if (beat_take) begin
            if (!load_none) begin
                data_d  = bus.s_data;
                keep_d  = bus.s_keep;
                last_d  = bus.s_last;
                idx_d   = load_idx;
                state_d = S_SEND;
            end else begin
                state_d = S_IDLE;
                if (bus.s_last) begin
                    pkt_inc = pkt_inc + 2'd1;
                end
            end
        end

        pkt_done_d = (pkt_inc != 2'd0);
        pkt_d      = pkt_count + CNT_WIDTH'(pkt_inc);
    end

    // State, holding register and counters.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            data_q     <= '0;
            keep_q     <= '0;
            last_q     <= 1'b0;
            pkt_done   <= 1'b0;
            byte_count <= '0;
            pkt_count  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            keep_q     <= keep_d;
            last_q     <= last_d;
            pkt_done   <= pkt_done_d;
            byte_count <= byte_d;
            pkt_count  <= pkt_d;
        end
    end

endmodule
